coin_acceptor: RTL and testbench
================================

# coin_acceptor

Front-end stage that converts the two raw coin-sensor lines of the vending unit into the clean 2-bit coin code consumed by the drink vending FSM. Each sensor line is synchronised, debounced and edge-detected. Each accepted insertion is emitted as exactly one single-cycle code, followed by a guaranteed idle gap so the downstream FSM sees every coin as a distinct value change. Simultaneous inserts, overflows and jammed sensors are detected and flagged.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable synchronised cycles required before a level change is accepted (≥1)
- GAP_CYCLES, 2, cycles of code 2'b00 forced after every emitted code (≥1)
- JAM_CYCLES, 1000, continuous debounced-high cycles after which a line is declared jammed (> DEBOUNCE_CYCLES)

Ports:
- clk  in  1  single system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- sens_5  in  1  raw 5-unit coin sensor; asynchronous; high while a coin passes
- sens_10  in  1  raw 10-unit coin sensor; asynchronous
- coin  out  2  registered coin code: 2'b00 none, 2'b01 five, 2'b10 ten; never 2'b11
- reject  out  1  one-cycle pulse when simultaneous 5/10 events are discarded
- overflow  out  1  one-cycle pulse when an event is dropped because its channel's pending slot is full
- jam  out  2  bit0 = 5-line jammed, bit1 = 10-line jammed; level

## Operation
- Per channel: 2-flop synchroniser, then debounce counter. The debounced level toggles after the synchronised value has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any agreeing sample clears the counter.
- Event: debounced 0→1 transition. Falling transitions produce no event.
- Same-cycle events on both channels: both discarded, reject=1 for one cycle, pending slots unchanged.
- Each channel has a 1-deep pending flag, set by its event:
  - If the flag is already set, the new event is dropped and overflow pulses.
  - If the flag is cleared in the same cycle a new event arrives, the new event is kept (flag stays 1).
- Output FSM:
  - IDLE: if any pending flag is set, load coin, clear that flag, go to EMIT. Priority is 5 over 10.
  - EMIT (1 cycle, coin driven): next state is GAP and coin returns to 00. The GAP counter starts at GAP_CYCLES.
  - GAP: coin=00; decrement the counter; return to IDLE when the counter reaches 0.
- Jam: a per-channel counter runs while the debounced level is 1 and saturates at JAM_CYCLES. jam bit sets on reaching JAM_CYCLES and clears in the cycle the debounced level falls. Jam does not suppress the original rising event.
- Reset (any time, including mid-EMIT/GAP):
  - All flops cleared; FSM is in IDLE.
  - Outputs: coin=00, reject=0, overflow=0, jam=00.
  - Synchroniser and debounced levels are 0. A line held high through reset therefore produces one event after release.

## Timing
- Idle latency: raw high sampled at edge k → synchroniser output high at k+2 → debounced level high at k+1+DEBOUNCE_CYCLES → event registered into pending → coin valid after edge k+3+DEBOUNCE_CYCLES.
- Back-to-back coins are spaced 2+GAP_CYCLES cycles apart at the coin port: EMIT plus GAP_CYCLES, plus one IDLE cycle.
- reject and overflow are registered, asserted the cycle after the offending event.
- Glitches shorter than DEBOUNCE_CYCLES synchronised cycles produce no event.

## Configuration
- COIN_ACCEPTOR_COUNT_EN defined:
  - Adds outputs total_5 (16-bit) and total_10 (16-bit).
  - Each counts emitted codes of its type, saturating at 16'hFFFF.
  - Both cleared by rst.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

## Structure
- Shared package coin_pkg holds:
  - COIN_NONE/COIN_5/COIN_10 code constants, shared with the drink vending FSM.
  - The output-FSM state encoding (IDLE=2'b00, EMIT=2'b01, GAP=2'b10).
- Sub-module coin_debounce, instantiated twice, contains:
  - synchroniser, debounce counter, rising-event pulse, jam counter and jam flag.
- Top level holds the conflict/pending logic, the output FSM and the optional totals.

## Test plan
- Clean 5 insert (sens_5 high 10 cycles, defaults) → coin=01 for exactly 1 cycle, 7 cycles after first sampled edge; then 00.
- 3-cycle glitch on sens_10 → coin stays 00, no flags.
- sens_5 and sens_10 rise on the same edge → reject pulses once, coin stays 00.
- Pulse sens_10, then sens_5 while in GAP → coin=10, then 00 for 2 cycles, IDLE 1 cycle, then coin=01.
- Hold sens_5 high for 1200 cycles → one coin=01, jam[0]=1 after 1000 debounced-high cycles, clears when the line falls.
- Assert rst during EMIT → coin=00 immediately. With COIN_ACCEPTOR_COUNT_EN: 3 tens inserted gives total_10=3 and total_5=0.

Source files
------------

// File: rtl/coin_pkg.sv
// ----------------------------------------------------------------------------
// Module  : coin_pkg
// Brief   : Coin code constants, output-FSM state encoding and a saturating
//           increment helper shared by the coin acceptor and the vending FSM.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

package coin_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EMIT = 2'b01,
    ST_GAP  = 2'b10
  } state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/coin_acceptor_if.sv
// ----------------------------------------------------------------------------
// Module  : coin_acceptor_if
// Brief   : Sensor inputs and coin/flag outputs of the coin acceptor.
//           COIN_ACCEPTOR_COUNT_EN adds the total_5/total_10 counters.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

interface coin_acceptor_if;
  logic       sens_5;
  logic       sens_10;
  logic [1:0] coin;
  logic       reject;
  logic       overflow;
  logic [1:0] jam;
`ifdef COIN_ACCEPTOR_COUNT_EN
  logic [15:0] total_5;
  logic [15:0] total_10;

  modport master (output sens_5, sens_10,
                  input  coin, reject, overflow, jam, total_5, total_10);
  modport slave  (input  sens_5, sens_10,
                  output coin, reject, overflow, jam, total_5, total_10);
`else
  modport master (output sens_5, sens_10,
                  input  coin, reject, overflow, jam);
  modport slave  (input  sens_5, sens_10,
                  output coin, reject, overflow, jam);
`endif
endinterface

`default_nettype wire

// File: rtl/coin_debounce.sv
// ----------------------------------------------------------------------------
// Module  : coin_debounce
// Brief   : One sensor channel: 2-flop synchroniser, debounce counter,
//           registered rising-event pulse, jam counter and jam flag.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module coin_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int JAM_CYCLES      = 1000
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_raw,
  output logic      o_event,
  output logic      o_jam
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int JW = $clog2(JAM_CYCLES + 1);
  localparam logic [DW-1:0] c_DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [JW-1:0] c_JAM_MAX  = JW'(JAM_CYCLES);
  localparam logic [JW-1:0] c_JAM_LAST = JW'(JAM_CYCLES - 1);

  logic          r_sync1, r_sync2, r_level, r_event, r_jam;
  logic [DW-1:0] r_db_cnt;
  logic [JW-1:0] r_jam_cnt;
  logic          w_toggle;

  // The debounced level flips on the last of DEBOUNCE_CYCLES disagreeing samples.
  assign w_toggle = (r_sync2 != r_level) && (r_db_cnt == c_DB_LAST);

  // Two-flop synchroniser for the asynchronous raw sensor.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce: count consecutive disagreeing samples, any agreeing one restarts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_db_cnt <= '0;
      r_level  <= 1'b0;
    end else if (r_sync2 == r_level || w_toggle) begin
      r_db_cnt <= '0;
      r_level  <= r_level ^ w_toggle;
    end else begin
      r_db_cnt <= r_db_cnt + DW'(1);
    end
  end

  // Single-cycle event on a debounced 0->1 transition only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_event <= 1'b0;
    else     r_event <= w_toggle & ~r_level;
  end

  // Jam: saturating high-time counter; the flag drops with the debounced level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_jam_cnt <= '0;
      r_jam     <= 1'b0;
    end else if (!r_level || w_toggle) begin
      r_jam_cnt <= '0;
      r_jam     <= 1'b0;
    end else if (r_jam_cnt != c_JAM_MAX) begin
      r_jam_cnt <= r_jam_cnt + JW'(1);
      if (r_jam_cnt == c_JAM_LAST) r_jam <= 1'b1;
    end
  end

  assign o_event = r_event;
  assign o_jam   = r_jam;

endmodule

`default_nettype wire

// File: rtl/coin_acceptor.sv
// ----------------------------------------------------------------------------
// Module  : coin_acceptor
// Brief   : Turns the two raw coin sensors into single-cycle coin codes with
//           a guaranteed idle gap; flags reject, overflow and jam.
//           COIN_ACCEPTOR_COUNT_EN adds saturating per-type emit totals.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module coin_acceptor
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int GAP_CYCLES      = 2,
  parameter int JAM_CYCLES      = 1000
) (
  input wire logic        clk,
  input wire logic        rst,
  coin_acceptor_if.slave  bus
);

  localparam int GW = $clog2(GAP_CYCLES + 1);

  logic          w_ev5, w_ev10, w_jam5, w_jam10;
  logic          w_both, w_ovf, w_clr5, w_clr10;
  logic          w_pend5_nxt, w_pend10_nxt;
  logic          r_pend5, r_pend10, r_reject, r_ovf;
  logic [1:0]    r_coin, w_coin_nxt;
  logic [GW-1:0] r_gap_cnt, w_gap_nxt;
  state_t        r_state, w_state_nxt;

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .JAM_CYCLES(JAM_CYCLES)) u_db5 (
    .clk(clk), .rst(rst), .i_raw(bus.sens_5), .o_event(w_ev5), .o_jam(w_jam5)
  );

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .JAM_CYCLES(JAM_CYCLES)) u_db10 (
    .clk(clk), .rst(rst), .i_raw(bus.sens_10), .o_event(w_ev10), .o_jam(w_jam10)
  );

  // Output FSM next-state: load a pending coin (5 first), emit, then hold the gap.
  always_comb begin
    w_state_nxt = r_state;
    w_coin_nxt  = COIN_NONE;
    w_clr5      = 1'b0;
    w_clr10     = 1'b0;
    w_gap_nxt   = r_gap_cnt;
    case (r_state)
      ST_IDLE: begin
        if (r_pend5) begin
          w_coin_nxt  = COIN_5;
          w_clr5      = 1'b1;
          w_state_nxt = ST_EMIT;
        end else if (r_pend10) begin
          w_coin_nxt  = COIN_10;
          w_clr10     = 1'b1;
          w_state_nxt = ST_EMIT;
        end
      end
      ST_EMIT: begin
        w_state_nxt = ST_GAP;
        w_gap_nxt   = GW'(GAP_CYCLES);
      end
      ST_GAP: begin
        w_gap_nxt = r_gap_cnt - GW'(1);
        if (r_gap_cnt == GW'(1)) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Pending slots: simultaneous events are both discarded; a full slot drops the event.
  always_comb begin
    w_both       = w_ev5 & w_ev10;
    w_ovf        = 1'b0;
    w_pend5_nxt  = r_pend5 & ~w_clr5;
    w_pend10_nxt = r_pend10 & ~w_clr10;
    if (!w_both) begin
      if (w_ev5) begin
        w_ovf       = w_pend5_nxt;
        w_pend5_nxt = 1'b1;
      end
      if (w_ev10) begin
        w_ovf        = w_ovf | w_pend10_nxt;
        w_pend10_nxt = 1'b1;
      end
    end
  end

  // State, coin code, pending slots and registered flag pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_coin    <= COIN_NONE;
      r_gap_cnt <= '0;
      r_pend5   <= 1'b0;
      r_pend10  <= 1'b0;
      r_reject  <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_coin    <= w_coin_nxt;
      r_gap_cnt <= w_gap_nxt;
      r_pend5   <= w_pend5_nxt;
      r_pend10  <= w_pend10_nxt;
      r_reject  <= w_both;
      r_ovf     <= w_ovf;
    end
  end

  assign bus.coin     = r_coin;
  assign bus.reject   = r_reject;
  assign bus.overflow = r_ovf;
  assign bus.jam      = {w_jam10, w_jam5};

`ifdef COIN_ACCEPTOR_COUNT_EN
  logic [15:0] r_total_5, r_total_10;

  // Count each code at the moment it is loaded for emission.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_total_5  <= '0;
      r_total_10 <= '0;
    end else begin
      if (w_clr5)  r_total_5  <= sat_inc16(r_total_5);
      if (w_clr10) r_total_10 <= sat_inc16(r_total_10);
    end
  end

  assign bus.total_5  = r_total_5;
  assign bus.total_10 = r_total_10;
`endif

endmodule

`default_nettype wire

// File: tb/tb_coin_acceptor.sv
// ----------------------------------------------------------------------------
// Module  : tb_coin_acceptor
// Brief   : Self-checking bench for coin_acceptor with a behavioural model.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_coin_acceptor;

  localparam int D = 4;
  localparam int G = 2;
  localparam int J = 1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  coin_acceptor_if bus();

  coin_acceptor #(.DEBOUNCE_CYCLES(D), .GAP_CYCLES(G), .JAM_CYCLES(J)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_s1[2], m_s2[2], m_lvl[2], m_ev[2], m_run[2], m_jam[2], m_pend[2], m_nh[2];
  int m_hist[2][D];
  int m_coin, m_hold, m_rej, m_ovf;
  int m_tot[2];

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_s1[c] = 0; m_s2[c] = 0; m_lvl[c] = 0; m_ev[c] = 0; m_run[c] = 0;
      m_jam[c] = 0; m_pend[c] = 0; m_nh[c] = 0; m_tot[c] = 0;
      for (int i = 0; i < D; i++) m_hist[c][i] = 0;
    end
    m_coin = 0; m_hold = 0; m_rej = 0; m_ovf = 0;
  endtask

  task automatic model_step(input logic r5, input logic r10);
    int raw[2], lvl_n[2], ev_n[2], run_n[2], jam_n[2], pend_n[2];
    int tog, load;
    raw[0] = r5 ? 1 : 0;
    raw[1] = r10 ? 1 : 0;
    for (int c = 0; c < 2; c++) begin
      for (int i = D - 1; i > 0; i--) m_hist[c][i] = m_hist[c][i-1];
      m_hist[c][0] = m_s2[c];
      if (m_nh[c] < D) m_nh[c]++;
      tog = (m_nh[c] >= D) ? 1 : 0;
      for (int i = 0; i < D; i++) if (m_hist[c][i] == m_lvl[c]) tog = 0;
      lvl_n[c] = tog ? 1 - m_lvl[c] : m_lvl[c];
      ev_n[c]  = (tog == 1 && m_lvl[c] == 0) ? 1 : 0;
      run_n[c] = m_lvl[c] ? ((m_run[c] < J) ? m_run[c] + 1 : J) : 0;
      jam_n[c] = (lvl_n[c] == 1 && run_n[c] >= J) ? 1 : 0;
    end
    load = -1;
    if (m_hold == 0) begin
      if (m_pend[0]) load = 0;
      else if (m_pend[1]) load = 1;
    end
    for (int c = 0; c < 2; c++) pend_n[c] = (m_pend[c] && load != c) ? 1 : 0;
    m_rej = (m_ev[0] && m_ev[1]) ? 1 : 0;
    m_ovf = 0;
    if (!m_rej) begin
      for (int c = 0; c < 2; c++) if (m_ev[c]) begin
        if (pend_n[c]) m_ovf = 1;
        pend_n[c] = 1;
      end
    end
    m_coin = (load == 0) ? 1 : (load == 1) ? 2 : 0;
    m_hold = (load >= 0) ? G + 1 : (m_hold > 0 ? m_hold - 1 : 0);
    if (load >= 0 && m_tot[load] < 65535) m_tot[load]++;
    for (int c = 0; c < 2; c++) begin
      m_s2[c] = m_s1[c]; m_s1[c] = raw[c];
      m_lvl[c] = lvl_n[c]; m_ev[c] = ev_n[c]; m_run[c] = run_n[c];
      m_jam[c] = jam_n[c]; m_pend[c] = pend_n[c];
    end
  endtask

  // Compare process: step the model at every edge and check all outputs.
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      #1;
      if (rst) model_reset();
      else begin
        model_step(bus.sens_5, bus.sens_10);
        chk("coin", 32'(bus.coin), 32'(m_coin));
        chk("reject", 32'(bus.reject), 32'(m_rej));
        chk("overflow", 32'(bus.overflow), 32'(m_ovf));
        chk("jam", 32'(bus.jam), 32'(m_jam[1] * 2 + m_jam[0]));
`ifdef COIN_ACCEPTOR_COUNT_EN
        chk("total_5", 32'(bus.total_5), 32'(m_tot[0]));
        chk("total_10", 32'(bus.total_10), 32'(m_tot[1]));
`endif
      end
    end
  end

  // ---------------- directed helpers ----------------
  int o_first5, o_first10, o_n5, o_n10, o_rej, o_ovf, o_jfirst, o_jlast;

  // Drive pulses (start index, length per line) and gather per-edge statistics.
  task automatic run(input int n, input int a5, input int l5, input int a10, input int l10);
    o_first5 = -1; o_first10 = -1; o_n5 = 0; o_n10 = 0;
    o_rej = 0; o_ovf = 0; o_jfirst = -1; o_jlast = -1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.sens_5  = (i >= a5 && i < a5 + l5);
      bus.sens_10 = (i >= a10 && i < a10 + l10);
      @(posedge clk);
      #1;
      if (bus.coin == 2'b01) begin o_n5++;  if (o_first5 < 0)  o_first5 = i; end
      if (bus.coin == 2'b10) begin o_n10++; if (o_first10 < 0) o_first10 = i; end
      if (bus.reject)   o_rej++;
      if (bus.overflow) o_ovf++;
      if (bus.jam[0]) begin o_jlast = i; if (o_jfirst < 0) o_jfirst = i; end
    end
  endtask

  int found;
  int rem5, rem10;

  initial begin
    bus.sens_5 = 1'b0;
    bus.sens_10 = 1'b0;
    #1;
    chk("reset_coin", 32'(bus.coin), 32'd0);
    chk("reset_flags", 32'({bus.reject, bus.overflow, bus.jam}), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Clean 5 insert: coin=01 once, 7 edges after the first sampled edge.
    run(30, 0, 10, -1, 0);
    chk("clean5_latency", 32'(o_first5), 32'd7);
    chk("clean5_count", 32'(o_n5), 32'd1);

    // 3-cycle glitch on the 10 line.
    run(25, -1, 0, 0, 3);
    chk("glitch_coins", 32'(o_n5 + o_n10), 32'd0);
    chk("glitch_flags", 32'(o_rej + o_ovf), 32'd0);

    // Simultaneous rise: one reject, nothing emitted.
    run(30, 0, 8, 0, 8);
    chk("simul_reject", 32'(o_rej), 32'd1);
    chk("simul_coins", 32'(o_n5 + o_n10), 32'd0);

    // Ten first, five arriving while in GAP: spaced 2+GAP apart.
    run(35, 3, 6, 0, 6);
    chk("gap_first10", 32'(o_first10), 32'd7);
    chk("gap_first5", 32'(o_first5), 32'd11);
    chk("gap_counts", 32'(o_n5 * 16 + o_n10), 32'h11);

    // Long hold on the 5 line: one coin, jam after 1000 debounced-high cycles.
    run(1230, 0, 1200, -1, 0);
    chk("jam_coin_count", 32'(o_n5), 32'd1);
    chk("jam_set_edge", 32'(o_jfirst), 32'd1005);
    chk("jam_clear_edge", 32'(o_jlast), 32'd1204);

    // Square waves on both lines, offset by half a period.
    for (int i = 0; i < 160; i++) begin
      @(negedge clk);
      bus.sens_5  = (i % 8) < 4;
      bus.sens_10 = ((i + 4) % 8) < 4;
    end
    run(30, -1, 0, -1, 0);

    // Reset asserted during EMIT clears the coin immediately.
    @(negedge clk);
    bus.sens_10 = 1'b1;
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      @(posedge clk);
      #1;
      if (bus.coin == 2'b10) found = 1;
    end
    chk("emit_seen", 32'(found), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst_emit_coin", 32'(bus.coin), 32'd0);
    bus.sens_10 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    run(20, -1, 0, -1, 0);

    // Three tens after reset.
    for (int k = 0; k < 3; k++) run(20, -1, 0, 0, 6);
`ifdef COIN_ACCEPTOR_COUNT_EN
    chk("total_10_three", 32'(bus.total_10), 32'd3);
    chk("total_5_zero", 32'(bus.total_5), 32'd0);
`endif

    // Randomized phase with one mid-run reset.
    rem5 = 0; rem10 = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst = (i == 1500);
      if ($urandom_range(0, 39) == 0) begin
        bus.sens_5 = 1'b1; bus.sens_10 = 1'b1;
        rem5 = 8; rem10 = 8;
      end
      if (rem5 == 0) begin bus.sens_5 = 1'($urandom_range(0, 1)); rem5 = $urandom_range(1, 12); end
      if (rem10 == 0) begin bus.sens_10 = 1'($urandom_range(0, 1)); rem10 = $urandom_range(1, 12); end
      rem5--; rem10--;
    end
    run(30, -1, 0, -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
